// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scan-code decoder: E0/F0 prefix parser, code-to-ASCII table, held-key
// tracking and an event FIFO with valid/ready pop.
module ps2_key_event_decoder #(
  parameter int                     NUM_KEYS      = 4,
  parameter int                     FIFO_DEPTH    = 8,
  parameter bit                     FILTER_REPEAT = 1'b1,
  parameter logic [9*NUM_KEYS-1:0]  SCAN_CODES    = {9'h01B, 9'h029, 9'h023, 9'h01C},
  parameter logic [8*NUM_KEYS-1:0]  ASCII_CODES   = {8'd83, 8'd32, 8'd68, 8'd65}
) (
  input  logic                inclock,
  input  logic                resetn,
  input  logic [7:0]          ps2_key_data,
  input  logic                ps2_key_pressed,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [7:0]          evt_ascii,
  output logic                evt_break,
  output logic [3:0]          evt_index,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [6:0]          fifo_count,
  output logic                overflow,
  output logic [7:0]          last_data_received
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0] DEPTH_C = 7'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                data_byte_s, ext_s, brk_s;
  logic [8:0]          code_s;
  logic                hit_s, held_s;
  logic [3:0]          idx_s;
  logic [7:0]          ascii_s;
  logic                evt_hit_s, filt_s, push_s, pop_s, full_s, wr_en_s, drop_s;
  logic [NUM_KEYS-1:0] key_held_r, held_nxt_s;
  logic [7:0]          last_r;
  logic                overflow_r;
  logic [12:0]         mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [6:0]          count_r;
  logic [12:0]         head_s;

  // Parser state register
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Parser next state; E0 always restarts the sequence, F0 only adds the break flag
  always_comb begin
    state_nxt_s = state_r;
    data_byte_s = 1'b0;
    case (state_r)
      ST_BRK:     begin ext_s = 1'b0; brk_s = 1'b1; end
      ST_EXT:     begin ext_s = 1'b1; brk_s = 1'b0; end
      ST_EXT_BRK: begin ext_s = 1'b1; brk_s = 1'b1; end
      default:    begin ext_s = 1'b0; brk_s = 1'b0; end
    endcase
    if (ps2_key_pressed) begin
      if (ps2_key_data == 8'hE0) begin
        state_nxt_s = ST_EXT;
      end else if (ps2_key_data == 8'hF0) begin
        case (state_r)
          ST_IDLE: state_nxt_s = ST_BRK;
          ST_EXT:  state_nxt_s = ST_EXT_BRK;
          default: state_nxt_s = state_r;
        endcase
      end else begin
        data_byte_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Table lookup; scanning downward lets the lowest matching index win
  always_comb begin
    code_s  = {ext_s, ps2_key_data};
    hit_s   = 1'b0;
    idx_s   = 4'd0;
    ascii_s = 8'd0;
    held_s  = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (SCAN_CODES[9*i +: 9] == code_s) begin
        hit_s   = 1'b1;
        idx_s   = 4'(i);
        ascii_s = ASCII_CODES[8*i +: 8];
        held_s  = key_held_r[i];
      end else begin
        hit_s   = hit_s;
      end
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      held_nxt_s[i] = (4'(i) == idx_s) ? ~brk_s : key_held_r[i];
    end
  end

  assign evt_hit_s = data_byte_s & hit_s;
  assign filt_s    = FILTER_REPEAT & ~brk_s & held_s;
  assign push_s    = evt_hit_s & ~filt_s;
  assign pop_s     = (count_r != 7'd0) & evt_ready;
  assign full_s    = (count_r == DEPTH_C);
  // At full with a simultaneous pop the write lands in the slot being vacated
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign drop_s    = push_s & full_s & ~pop_s;

  // Held-key map, last-make ASCII and sticky overflow flag
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      key_held_r <= '0;
      last_r     <= 8'd0;
      overflow_r <= 1'b0;
    end else begin
      if (evt_hit_s) begin
        key_held_r <= held_nxt_s;
      end
      if (push_s && !brk_s) begin
        last_r <= ascii_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Event FIFO storage, pointers and occupancy
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 13'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 7'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {idx_s, ascii_s, brk_s};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + 7'd1;
        2'b01:   count_r <= count_r - 7'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_s             = mem_r[rd_ptr_r];
  assign evt_valid          = (count_r != 7'd0);
  assign evt_index          = evt_valid ? head_s[12:9] : 4'd0;
  assign evt_ascii          = evt_valid ? head_s[8:1]  : 8'd0;
  assign evt_break          = evt_valid ? head_s[0]    : 1'b0;
  assign key_held           = key_held_r;
  assign fifo_count         = count_r;
  assign overflow           = overflow_r;
  assign last_data_received = last_r;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: two instances (default table with repeat filter, and
// an extended/duplicate-code table without filter) checked against a queue-based model.
module tb_ps2_key_event_decoder;

  logic       inclock = 1'b0;
  logic       resetn;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       evt_ready;

  logic       a_valid, a_break, a_ovf, b_valid, b_break, b_ovf;
  logic [7:0] a_ascii, a_last, b_ascii, b_last;
  logic [3:0] a_index, a_held, b_index, b_held;
  logic [6:0] a_count, b_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 inclock = ~inclock;

  ps2_key_event_decoder dut_a (
    .inclock(inclock), .resetn(resetn), .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed), .evt_ready(evt_ready), .evt_valid(a_valid),
    .evt_ascii(a_ascii), .evt_break(a_break), .evt_index(a_index), .key_held(a_held),
    .fifo_count(a_count), .overflow(a_ovf), .last_data_received(a_last)
  );

  ps2_key_event_decoder #(
    .NUM_KEYS(4), .FIFO_DEPTH(8), .FILTER_REPEAT(1'b0),
    .SCAN_CODES({9'h074, 9'h01C, 9'h175, 9'h01C}),
    .ASCII_CODES({8'd82, 8'd90, 8'd76, 8'd65})
  ) dut_b (
    .inclock(inclock), .resetn(resetn), .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed), .evt_ready(evt_ready), .evt_valid(b_valid),
    .evt_ascii(b_ascii), .evt_break(b_break), .evt_index(b_index), .key_held(b_held),
    .fifo_count(b_count), .overflow(b_ovf), .last_data_received(b_last)
  );

  // reference model: prefix flags, held bits, event list kept front-first
  logic [8:0]  m_scan  [2][4];
  logic [7:0]  m_asc   [2][4];
  bit          m_filt  [2];
  bit          m_ext   [2];
  bit          m_brk   [2];
  logic [3:0]  m_held  [2];
  logic [7:0]  m_last  [2];
  bit          m_ovf   [2];
  logic [12:0] m_q     [2][64];
  int          m_n     [2];

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_ext[id] = 1'b0; m_brk[id] = 1'b0; m_held[id] = 4'd0;
      m_last[id] = 8'd0; m_ovf[id] = 1'b0; m_n[id] = 0;
    end
  endtask

  task automatic model_step(input int id, input logic [7:0] d, input logic s, input logic r);
    bit pop, push, full, found;
    int k;
    logic [12:0] ev;
    pop = (m_n[id] != 0) && r;
    full = (m_n[id] == 8);
    push = 1'b0; found = 1'b0; k = 0; ev = 13'd0;
    if (s) begin
      if (d == 8'hE0) begin
        m_ext[id] = 1'b1; m_brk[id] = 1'b0;
      end else if (d == 8'hF0) begin
        m_brk[id] = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++)
          if (!found && m_scan[id][i] == {m_ext[id], d}) begin found = 1'b1; k = i; end
        if (found) begin
          if (!(m_filt[id] && !m_brk[id] && m_held[id][k])) begin
            push = 1'b1;
            ev = {4'(k), m_asc[id][k], m_brk[id]};
            if (!m_brk[id]) m_last[id] = m_asc[id][k];
          end
          m_held[id][k] = !m_brk[id];
        end
        m_ext[id] = 1'b0; m_brk[id] = 1'b0;
      end
    end
    if (pop) begin
      for (int i = 0; i < 63; i++) m_q[id][i] = m_q[id][i+1];
      m_n[id] = m_n[id] - 1;
    end
    if (push) begin
      if (full && !pop) m_ovf[id] = 1'b1;
      else begin m_q[id][m_n[id]] = ev; m_n[id] = m_n[id] + 1; end
    end
  endtask

  function automatic logic [63:0] exp_vec(input int id);
    logic [12:0] h;
    h = (m_n[id] != 0) ? m_q[id][0] : 13'd0;
    return {30'd0, (m_n[id] != 0), h[12:9], h[8:1], h[0], m_held[id],
            7'(m_n[id]), m_ovf[id], m_last[id]};
  endfunction

  function automatic logic [63:0] act_vec(input int id);
    if (id == 0)
      return {30'd0, a_valid, a_index, a_ascii, a_break, a_held, a_count, a_ovf, a_last};
    else
      return {30'd0, b_valid, b_index, b_ascii, b_break, b_held, b_count, b_ovf, b_last};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic compare_model();
    check("A_model", act_vec(0), exp_vec(0));
    check("B_model", act_vec(1), exp_vec(1));
  endtask

  task automatic cycle(input logic [7:0] d, input logic s, input logic r);
    ps2_key_data = d; ps2_key_pressed = s; evt_ready = r;
    model_step(0, d, s, r);
    model_step(1, d, s, r);
    @(posedge inclock);
    @(negedge inclock);
    compare_model();
  endtask

  task automatic do_reset();
    ps2_key_pressed = 1'b0; evt_ready = 1'b0; ps2_key_data = 8'h00;
    resetn = 1'b0;
    model_reset();
    #2;
    compare_model();
    @(negedge inclock);
    resetn = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       strb;
    logic       rdy;
    logic       valid;
    logic [3:0] idx;
    logic [7:0] ascii;
    logic       brk;
    logic [3:0] held;
    logic [6:0] cnt;
    logic [7:0] last;
  } vec_t;

  vec_t tbl [11];
  logic [7:0] pool [9];

  initial begin
    tbl[0]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 4'd0, 8'd65, 1'b0, 4'b0001, 7'd1, 8'd65};
    tbl[1]  = '{8'hF0, 1'b1, 1'b0, 1'b1, 4'd0, 8'd65, 1'b0, 4'b0001, 7'd1, 8'd65};
    tbl[2]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 4'd0, 8'd65, 1'b0, 4'b0000, 7'd2, 8'd65};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 4'd0, 8'd65, 1'b1, 4'b0000, 7'd1, 8'd65};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0,  1'b0, 4'b0000, 7'd0, 8'd65};
    tbl[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0,  1'b0, 4'b0000, 7'd0, 8'd65};
    tbl[6]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0,  1'b0, 4'b0000, 7'd0, 8'd65};
    tbl[7]  = '{8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0,  1'b0, 4'b0000, 7'd0, 8'd65};
    tbl[8]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0,  1'b0, 4'b0000, 7'd0, 8'd65};
    tbl[9]  = '{8'h1B, 1'b1, 1'b0, 1'b1, 4'd3, 8'd83, 1'b0, 4'b1000, 7'd1, 8'd83};
    tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0,  1'b0, 4'b1000, 7'd0, 8'd83};
    pool = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h29, 8'h1B, 8'h75, 8'h74, 8'h5A};

    m_scan[0] = '{9'h01C, 9'h023, 9'h029, 9'h01B};
    m_asc[0]  = '{8'd65, 8'd68, 8'd32, 8'd83};
    m_scan[1] = '{9'h01C, 9'h175, 9'h01C, 9'h074};
    m_asc[1]  = '{8'd65, 8'd76, 8'd90, 8'd82};
    m_filt[0] = 1'b1;
    m_filt[1] = 1'b0;

    // power-on reset
    do_reset();
    check("A_reset_zero", act_vec(0), 64'd0);

    // reset mid-stream: E0 must be forgotten, so 75 becomes a plain-code miss
    cycle(8'hE0, 1'b1, 1'b0);
    do_reset();
    cycle(8'h75, 1'b1, 1'b0);
    check("B_no_event_after_reset", {63'd0, b_valid}, 64'd0);

    // directed table on instance A
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].data, tbl[i].strb, tbl[i].rdy);
      check($sformatf("tbl_row%0d", i),
            {30'd0, a_valid, a_index, a_ascii, a_break, a_held, a_count, a_last},
            {30'd0, tbl[i].valid, tbl[i].idx, tbl[i].ascii, tbl[i].brk, tbl[i].held,
             tbl[i].cnt, tbl[i].last});
    end

    // typematic repeats: filtered on A, all kept on B
    do_reset();
    for (int i = 0; i < 3; i++) cycle(8'h1C, 1'b1, 1'b0);
    check("A_repeat_count", {57'd0, a_count}, 64'd1);
    check("B_repeat_count", {57'd0, b_count}, 64'd3);
    cycle(8'hF0, 1'b1, 1'b0);
    cycle(8'h1C, 1'b1, 1'b0);
    drain(6);

    // extended code on B: make, break, plain miss, repeated F0, E0 restart after F0
    do_reset();
    cycle(8'hE0, 1'b1, 1'b0); cycle(8'h75, 1'b1, 1'b0);
    cycle(8'hE0, 1'b1, 1'b0); cycle(8'hF0, 1'b1, 1'b0); cycle(8'h75, 1'b1, 1'b0);
    cycle(8'h75, 1'b1, 1'b0);
    cycle(8'hE0, 1'b1, 1'b0); cycle(8'hF0, 1'b1, 1'b0); cycle(8'hF0, 1'b1, 1'b0);
    cycle(8'h75, 1'b1, 1'b0);
    cycle(8'hF0, 1'b1, 1'b0); cycle(8'hE0, 1'b1, 1'b0); cycle(8'h75, 1'b1, 1'b0);
    check("B_ext_count", {57'd0, b_count}, 64'd4);
    check("B_ext_head", {51'd0, b_index, b_ascii, b_break}, {51'd0, 4'd1, 8'd76, 1'b0});
    drain(6);

    // overflow on A: eight events fill the FIFO, ninth make is dropped
    do_reset();
    cycle(8'h1C, 1'b1, 1'b0); cycle(8'hF0, 1'b1, 1'b0); cycle(8'h1C, 1'b1, 1'b0);
    cycle(8'h23, 1'b1, 1'b0); cycle(8'hF0, 1'b1, 1'b0); cycle(8'h23, 1'b1, 1'b0);
    cycle(8'h29, 1'b1, 1'b0); cycle(8'hF0, 1'b1, 1'b0); cycle(8'h29, 1'b1, 1'b0);
    cycle(8'h1B, 1'b1, 1'b0); cycle(8'hF0, 1'b1, 1'b0); cycle(8'h1B, 1'b1, 1'b0);
    check("A_full_no_ovf", {56'd0, a_count, a_ovf}, {56'd0, 7'd8, 1'b0});
    cycle(8'h1C, 1'b1, 1'b0);
    check("A_ovf_set", {48'd0, a_count, a_ovf, a_last}, {48'd0, 7'd8, 1'b1, 8'd65});
    cycle(8'hF0, 1'b1, 1'b0);
    cycle(8'h1C, 1'b1, 1'b1);
    check("A_full_push_pop", {56'd0, a_count, a_ovf}, {56'd0, 7'd8, 1'b1});
    drain(10);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] d;
      d = pool[$urandom_range(8, 0)];
      if ($urandom_range(7, 0) == 0) d = 8'($urandom);
      cycle(d, ($urandom_range(9, 0) < 7), ($urandom_range(1, 0) == 1));
      if (i == 2000) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
